laser_host: RTL and testbench

Host-side driver and scorer for the two-circle laser coverage engine. Holds a 40-point object list loaded by the system, releases the engine from reset, and streams the points one per cycle on the engine's X/Y input. It then waits for the engine's DONE pulse, captures the two circle centres, and scores them by counting the objects covered by either circle. It sits between the system controller and the coverage engine, and drives the engine's active-high reset.

---
 rtl/laser_host_pkg.sv | 22 ++
 rtl/laser_host_if.sv | 39 +++
 rtl/laser_cover_chk.sv | 26 ++
 rtl/laser_host.sv | 157 +++++++++++++++
 tb/tb_laser_host.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/laser_host_pkg.sv
// Shared types and sizes for the laser coverage host: frame size, coordinate
// and score widths, the host FSM states and the packed point layout.
package laser_pkg;

  localparam int OBJ_NUM = 40;
  localparam int COORD_W = 4;
  localparam int SCORE_W = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT,
    S_SCORE,
    S_REPORT
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } point_t;

endpackage

// File: rtl/laser_host_if.sv
// Bundle of the system-side load/start/result signals and the engine-side
// stream/reset/centre signals of the laser host.
interface laser_host_if;
  import laser_pkg::*;

  // LD_VALID, START and DONE are single-beat strobes with no ready: a strobe
  // is taken on the rising edge that samples it high, and only in the state
  // that owns it (LD_VALID/START in IDLE, DONE in WAIT); elsewhere it is dropped.
  logic               LD_VALID;
  logic [COORD_W-1:0] LD_X;
  logic [COORD_W-1:0] LD_Y;
  logic               START;
  logic               LASER_RST;
  logic [COORD_W-1:0] X;
  logic [COORD_W-1:0] Y;
  logic               DONE;
  logic [COORD_W-1:0] C1X;
  logic [COORD_W-1:0] C1Y;
  logic [COORD_W-1:0] C2X;
  logic [COORD_W-1:0] C2Y;
  logic [COORD_W-1:0] R_C1X;
  logic [COORD_W-1:0] R_C1Y;
  logic [COORD_W-1:0] R_C2X;
  logic [COORD_W-1:0] R_C2Y;
  logic [SCORE_W-1:0] SCORE;
  logic               SCORE_VALID;
  logic               ERR;

  modport master (
    output LD_VALID, LD_X, LD_Y, START, DONE, C1X, C1Y, C2X, C2Y,
    input  LASER_RST, X, Y, R_C1X, R_C1Y, R_C2X, R_C2Y, SCORE, SCORE_VALID, ERR
  );

  modport slave (
    input  LD_VALID, LD_X, LD_Y, START, DONE, C1X, C1Y, C2X, C2Y,
    output LASER_RST, X, Y, R_C1X, R_C1Y, R_C2X, R_C2Y, SCORE, SCORE_VALID, ERR
  );

endinterface

// File: rtl/laser_cover_chk.sv
// Combinational inside test of one point against one circle centre of radius 4
// on the integer grid, using non-wrapping absolute distances.
module laser_cover_chk
  import laser_pkg::*;
(
  input  point_t pt,
  input  point_t ctr,
  output logic   covered
);

  logic [COORD_W:0]   dx_raw, dy_raw, dx, dy;
  logic [COORD_W+1:0] sum;

  always_comb begin
    dx_raw = {1'b0, ctr.x} - {1'b0, pt.x};
    dy_raw = {1'b0, ctr.y} - {1'b0, pt.y};
    dx     = dx_raw[COORD_W] ? (~dx_raw + 1'b1) : dx_raw;
    dy     = dy_raw[COORD_W] ? (~dy_raw + 1'b1) : dy_raw;
    sum    = {1'b0, dx} + {1'b0, dy};
    // The two (2,3)/(3,2) corners are the only points with dx+dy>4 inside r=4.
    covered = (sum <= 6'd4) ||
              ((dx == 5'd2) && (dy == 5'd3)) ||
              ((dx == 5'd3) && (dy == 5'd2));
  end

endmodule

// File: rtl/laser_host.sv
// Host for the two-circle laser engine: loads a frame of points, streams it to
// the engine, captures the returned centres and scores the covered objects.
module laser_host #(
  parameter int          OBJ_NUM  = laser_pkg::OBJ_NUM,
  parameter int          PARALLEL = 5,
  parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
  input  logic              CLK,
  input  logic              RST_N,
  laser_host_if.slave       bus,
  output laser_pkg::state_t dbg_state
);
  import laser_pkg::*;

  localparam int CNT_W  = $clog2(OBJ_NUM + 1);
  localparam int GROUPS = OBJ_NUM / PARALLEL;

  state_t             state, state_nxt;
  point_t             mem [OBJ_NUM];
  logic [CNT_W-1:0]   ld_cnt, cnt;
  logic [15:0]        wcnt;
  logic [SCORE_W-1:0] acc, group_pop;
  logic               timed_out;
  logic               ld_full, start_ok, stream_last, score_last, timeout_hit;
  point_t             c1, c2;
  point_t             chk_pt [PARALLEL];
  logic [PARALLEL-1:0] cov1, cov2;

  assign ld_full     = (ld_cnt == CNT_W'(OBJ_NUM));
  assign start_ok    = (state == S_IDLE) && bus.START && ld_full;
  assign stream_last = (cnt == CNT_W'(OBJ_NUM - 1));
  assign score_last  = (cnt == CNT_W'(GROUPS - 1));
  assign timeout_hit = (wcnt == TIMEOUT);
  assign c1          = {bus.R_C1Y, bus.R_C1X};
  assign c2          = {bus.R_C2Y, bus.R_C2X};
  assign dbg_state   = state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_ok) state_nxt = S_STREAM;
      S_STREAM: if (stream_last) state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.DONE)        state_nxt = S_SCORE;
        else if (timeout_hit) state_nxt = S_REPORT;
      end
      S_SCORE:  if (score_last) state_nxt = S_REPORT;
      S_REPORT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // During SCORE, cnt selects the group of PARALLEL points under test.
  always_comb begin
    for (int i = 0; i < PARALLEL; i++) begin
      int idx;
      idx       = int'(cnt) * PARALLEL + i;
      chk_pt[i] = (idx < OBJ_NUM) ? mem[idx[CNT_W-1:0]] : '0;
    end
  end

  for (genvar g = 0; g < PARALLEL; g++) begin : g_chk
    laser_cover_chk u_chk1 (.pt(chk_pt[g]), .ctr(c1), .covered(cov1[g]));
    laser_cover_chk u_chk2 (.pt(chk_pt[g]), .ctr(c2), .covered(cov2[g]));
  end

  always_comb begin
    group_pop = '0;
    for (int i = 0; i < PARALLEL; i++) group_pop = group_pop + SCORE_W'(cov1[i] | cov2[i]);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < OBJ_NUM; i++) mem[i] <= '0;
      ld_cnt          <= '0;
      cnt             <= '0;
      wcnt            <= '0;
      acc             <= '0;
      timed_out       <= 1'b0;
      bus.LASER_RST   <= 1'b1;
      bus.X           <= '0;
      bus.Y           <= '0;
      bus.R_C1X       <= '0;
      bus.R_C1Y       <= '0;
      bus.R_C2X       <= '0;
      bus.R_C2Y       <= '0;
      bus.SCORE       <= '0;
      bus.SCORE_VALID <= 1'b0;
      bus.ERR         <= 1'b0;
    end else begin
      bus.SCORE_VALID <= 1'b0;
      bus.ERR         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.LD_VALID && !ld_full) begin
            mem[ld_cnt] <= {bus.LD_Y, bus.LD_X};
            ld_cnt      <= ld_cnt + 1'b1;
          end
          if (start_ok) begin
            bus.LASER_RST    <= 1'b0;
            {bus.Y, bus.X}   <= mem[0];
            cnt              <= '0;
            ld_cnt           <= '0;
          end
        end
        S_STREAM: begin
          if (stream_last) begin
            bus.X <= '0;
            bus.Y <= '0;
            wcnt  <= '0;
          end else begin
            {bus.Y, bus.X} <= mem[cnt + 1'b1];
            cnt            <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (bus.DONE) begin
            bus.R_C1X     <= bus.C1X;
            bus.R_C1Y     <= bus.C1Y;
            bus.R_C2X     <= bus.C2X;
            bus.R_C2Y     <= bus.C2Y;
            bus.LASER_RST <= 1'b1;
            acc           <= '0;
            cnt           <= '0;
          end else if (timeout_hit) begin
            bus.R_C1X     <= '0;
            bus.R_C1Y     <= '0;
            bus.R_C2X     <= '0;
            bus.R_C2Y     <= '0;
            bus.SCORE     <= '0;
            bus.LASER_RST <= 1'b1;
            acc           <= '0;
            timed_out     <= 1'b1;
          end
        end
        S_SCORE: begin
          acc <= acc + group_pop;
          cnt <= cnt + 1'b1;
        end
        S_REPORT: begin
          bus.SCORE_VALID <= 1'b1;
          bus.ERR         <= timed_out;
          bus.SCORE       <= acc;
          timed_out       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_host.sv
// Bench for laser_host: loads frames, acts as the engine, and compares the
// stream, captured centres and score against a distance-based reference.
module tb_laser_host;
  import laser_pkg::*;

  localparam logic [15:0] TB_TIMEOUT = 16'd300;
  localparam int          NPT        = 40;

  logic   CLK = 1'b0;
  logic   RST_N = 1'b0;
  state_t dbg_state;
  int     n_cmp = 0;
  int     n_bad = 0;
  logic [7:0] pts [NPT];
  logic [7:0] exp_q[$];

  laser_host_if bus ();

  laser_host #(.OBJ_NUM(NPT), .PARALLEL(5), .TIMEOUT(TB_TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic bit ref_in(int px, int py, int cx, int cy);
    int dx, dy;
    dx = px - cx;
    dy = py - cy;
    return (dx * dx + dy * dy) <= 16;
  endfunction

  function automatic int ref_score(int c1x, int c1y, int c2x, int c2y);
    int n = 0;
    for (int k = 0; k < NPT; k++) begin
      int px, py;
      px = int'(pts[k][3:0]);
      py = int'(pts[k][7:4]);
      if (ref_in(px, py, c1x, c1y) || ref_in(px, py, c2x, c2y)) n++;
    end
    return n;
  endfunction

  task automatic drive_idle();
    bus.LD_VALID = 1'b0;
    bus.LD_X = '0;
    bus.LD_Y = '0;
    bus.START = 1'b0;
    bus.DONE = 1'b0;
    {bus.C1X, bus.C1Y, bus.C2X, bus.C2Y} = '0;
  endtask

  task automatic ld_strobe(input logic [3:0] x, input logic [3:0] y);
    @(negedge CLK);
    bus.LD_VALID = 1'b1;
    bus.LD_X = x;
    bus.LD_Y = y;
    @(negedge CLK);
    bus.LD_VALID = 1'b0;
  endtask

  task automatic load_points(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      bus.LD_VALID = 1'b1;
      bus.LD_X = pts[k][3:0];
      bus.LD_Y = pts[k][7:4];
    end
    @(negedge CLK);
    bus.LD_VALID = 1'b0;
  endtask

  // Starts a frame and checks mem[k] on X/Y in the cycle after E_k; returns
  // early right after checking point stop_k when stop_k >= 0.
  task automatic stream_frame(input bit noise, input int stop_k);
    logic [7:0] exp;
    exp_q.delete();
    for (int k = 0; k < NPT; k++) exp_q.push_back(pts[k]);
    @(negedge CLK);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    n_cmp++;
    if (bus.LASER_RST !== 1'b0) begin
      n_bad++;
      $display("FAIL laser_rst_fall: got %b want 0", bus.LASER_RST);
    end
    for (int k = 0; k < NPT; k++) begin
      if (k > 0) @(negedge CLK);
      exp = exp_q.pop_front();
      n_cmp++;
      if ({bus.Y, bus.X} !== exp) begin
        n_bad++;
        $display("FAIL stream[%0d]: got %02h want %02h", k, {bus.Y, bus.X}, exp);
      end
      if (k == stop_k) return;
      if (noise && k < NPT - 1) begin
        bus.LD_VALID = 1'($urandom_range(0, 1));
        bus.LD_X = 4'($urandom);
        bus.LD_Y = 4'($urandom);
        bus.START = 1'($urandom_range(0, 1));
        bus.DONE = 1'($urandom_range(0, 1));
      end else begin
        bus.LD_VALID = 1'b0;
        bus.START = 1'b0;
        bus.DONE = 1'b0;
      end
    end
    @(negedge CLK);
    n_cmp++;
    if ({bus.LASER_RST, bus.Y, bus.X} !== 9'h000) begin
      n_bad++;
      $display("FAIL stream_end: got rst=%b xy=%02h want rst=0 xy=00", bus.LASER_RST, {bus.Y, bus.X});
    end
  endtask

  // Called at the first negedge in WAIT; plays the engine and checks the result.
  task automatic wait_result(input bit use_done, input int d, input int c1x, input int c1y,
                             input int c2x, input int c2y, input int exp_score);
    int         j = 0;
    bit         seen = 1'b0;
    int         exp_lat;
    logic [15:0] exp_r;
    exp_lat = use_done ? d + 10 : int'(TB_TIMEOUT) + 2;
    exp_r   = use_done ? {4'(c1x), 4'(c1y), 4'(c2x), 4'(c2y)} : 16'h0000;
    while (!seen && j < int'(TB_TIMEOUT) + 40) begin
      if (use_done && j == d) begin
        bus.DONE = 1'b1;
        {bus.C1X, bus.C1Y, bus.C2X, bus.C2Y} = {4'(c1x), 4'(c1y), 4'(c2x), 4'(c2y)};
      end else begin
        bus.DONE = 1'b0;
        {bus.C1X, bus.C1Y, bus.C2X, bus.C2Y} = 16'($urandom);
      end
      @(negedge CLK);
      j++;
      if (use_done && j == d + 1) begin
        n_cmp++;
        if (bus.LASER_RST !== 1'b1) begin
          n_bad++;
          $display("FAIL laser_rst_rise: got %b want 1", bus.LASER_RST);
        end
        n_cmp++;
        if ({bus.R_C1X, bus.R_C1Y, bus.R_C2X, bus.R_C2Y} !== exp_r) begin
          n_bad++;
          $display("FAIL capture: got %04h want %04h", {bus.R_C1X, bus.R_C1Y, bus.R_C2X, bus.R_C2Y}, exp_r);
        end
      end
      if (bus.SCORE_VALID === 1'b1) seen = 1'b1;
    end
    bus.DONE = 1'b0;
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL result_timeout: got no SCORE_VALID in %0d cycles want one at %0d", j, exp_lat);
      return;
    end
    n_cmp++;
    if (j !== exp_lat) begin
      n_bad++;
      $display("FAIL latency: got %0d want %0d", j, exp_lat);
    end
    n_cmp++;
    if (bus.SCORE !== 6'(exp_score)) begin
      n_bad++;
      $display("FAIL score: got %0d want %0d", bus.SCORE, exp_score);
    end
    n_cmp++;
    if (bus.ERR !== !use_done) begin
      n_bad++;
      $display("FAIL err: got %b want %b", bus.ERR, !use_done);
    end
    n_cmp++;
    if ({bus.R_C1X, bus.R_C1Y, bus.R_C2X, bus.R_C2Y} !== exp_r) begin
      n_bad++;
      $display("FAIL r_hold: got %04h want %04h", {bus.R_C1X, bus.R_C1Y, bus.R_C2X, bus.R_C2Y}, exp_r);
    end
    @(negedge CLK);
    n_cmp++;
    if ({bus.SCORE_VALID, bus.ERR, bus.LASER_RST, bus.SCORE} !== {2'b00, 1'b1, 6'(exp_score)}) begin
      n_bad++;
      $display("FAIL after_pulse: got sv=%b err=%b rst=%b score=%0d want sv=0 err=0 rst=1 score=%0d",
               bus.SCORE_VALID, bus.ERR, bus.LASER_RST, bus.SCORE, exp_score);
    end
  endtask

  task automatic run_frame(input int c1x, input int c1y, input int c2x, input int c2y,
                           input int d, input bit noise, input int exp_score);
    load_points(NPT);
    stream_frame(noise, -1);
    wait_result(1'b1, d, c1x, c1y, c2x, c2y, exp_score);
  endtask

  task automatic test_reset();
    drive_idle();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if ({bus.LASER_RST, bus.Y, bus.X} !== 9'h100) begin
      n_bad++;
      $display("FAIL reset_stream: got %03h want 100", {bus.LASER_RST, bus.Y, bus.X});
    end
    n_cmp++;
    if ({bus.R_C1X, bus.R_C1Y, bus.R_C2X, bus.R_C2Y, bus.SCORE, bus.SCORE_VALID, bus.ERR} !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_result: got %06h want 000000",
               {bus.R_C1X, bus.R_C1Y, bus.R_C2X, bus.R_C2Y, bus.SCORE, bus.SCORE_VALID, bus.ERR});
    end
    n_cmp++;
    if (dbg_state !== S_IDLE) begin
      n_bad++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE);
    end
  endtask

  task automatic test_all_center();
    for (int k = 0; k < NPT; k++) pts[k] = 8'h88;
    run_frame(8, 8, 0, 0, $urandom_range(0, 20), 1'b0, 40);
  endtask

  task automatic test_grid();
    int extra [8][2] = '{'{5, 6}, '{6, 5}, '{6, 6}, '{3, 8}, '{7, 3}, '{3, 7}, '{8, 3}, '{1, 6}};
    for (int k = 0; k < 16; k++) pts[k] = {4'(k), 4'(k)};
    for (int k = 0; k < 16; k++) pts[16 + k] = {4'(15 - k), 4'(k)};
    for (int k = 0; k < 8; k++) pts[32 + k] = {4'(extra[k][1]), 4'(extra[k][0])};
    run_frame(3, 3, 12, 12, $urandom_range(0, 20), 1'b0, ref_score(3, 3, 12, 12));
  endtask

  // Uniform frames: {px, py, c1x, c1y, expected score}, second centre at (15,15).
  task automatic test_boundary();
    int tbl [8][5] = '{'{0, 0, 15, 15, 0}, '{0, 0, 4, 0, 40}, '{0, 0, 0, 4, 40}, '{0, 0, 1, 4, 0},
                       '{5, 6, 3, 3, 40}, '{6, 5, 3, 3, 40}, '{6, 6, 3, 3, 0}, '{3, 8, 3, 3, 0}};
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < NPT; k++) pts[k] = {4'(tbl[t][1]), 4'(tbl[t][0])};
      run_frame(tbl[t][2], tbl[t][3], 15, 15, $urandom_range(0, 5), 1'b0, tbl[t][4]);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int c [4];
      for (int k = 0; k < NPT; k++) pts[k] = 8'($urandom);
      for (int i = 0; i < 4; i++) c[i] = $urandom_range(0, 15);
      run_frame(c[0], c[1], c[2], c[3], $urandom_range(0, 30), 1'b1, ref_score(c[0], c[1], c[2], c[3]));
    end
  endtask

  task automatic test_load_rules();
    for (int k = 0; k < NPT; k++) pts[k] = 8'($urandom);
    load_points(NPT - 1);
    @(negedge CLK);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({bus.LASER_RST, bus.Y, bus.X} !== 9'h100) begin
        n_bad++;
        $display("FAIL start_39[%0d]: got %03h want 100", i, {bus.LASER_RST, bus.Y, bus.X});
      end
      @(negedge CLK);
    end
    ld_strobe(pts[NPT-1][3:0], pts[NPT-1][7:4]);
    ld_strobe(4'h5, 4'hA);
    stream_frame(1'b0, -1);
    wait_result(1'b1, 3, 2, 9, 11, 4, ref_score(2, 9, 11, 4));
  endtask

  task automatic test_timeout();
    for (int k = 0; k < NPT; k++) pts[k] = 8'($urandom);
    load_points(NPT);
    stream_frame(1'b0, -1);
    wait_result(1'b0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < NPT; k++) pts[k] = 8'($urandom);
    run_frame(8, 8, 1, 2, int'(TB_TIMEOUT), 1'b0, ref_score(8, 8, 1, 2));
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < NPT; k++) pts[k] = 8'($urandom);
    load_points(NPT);
    stream_frame(1'b0, 20);
    #2 RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({bus.LASER_RST, bus.Y, bus.X, bus.R_C1X, bus.R_C1Y, bus.R_C2X, bus.R_C2Y,
         bus.SCORE, bus.SCORE_VALID, bus.ERR} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_mid: got rst=%b xy=%02h r=%04h score=%0d sv=%b err=%b want rst=1 rest 0",
               bus.LASER_RST, {bus.Y, bus.X}, {bus.R_C1X, bus.R_C1Y, bus.R_C2X, bus.R_C2Y},
               bus.SCORE, bus.SCORE_VALID, bus.ERR);
    end
    n_cmp++;
    if (dbg_state !== S_IDLE) begin
      n_bad++;
      $display("FAIL reset_mid_state: got %0d want %0d", dbg_state, S_IDLE);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < NPT; k++) pts[k] = 8'($urandom);
    run_frame(4, 11, 13, 2, $urandom_range(0, 10), 1'b0, ref_score(4, 11, 13, 2));
  endtask

  initial begin
    test_reset();
    test_all_center();
    test_grid();
    test_boundary();
    test_random();
    test_load_rules();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
